execute_writeback: RTL and testbench

- Second stage of the two-stage RV32I core; consumes the registered decode bundle from the decode stage.
- Performs ALU/branch/jump resolution and sequences data-memory load/store through a req/ready handshake.
- Returns write_data and reg_write_valid for the register file.
- Returns jump_flag/jump_address (jump_flag drives pre_jump_flag_id) and stall to the fetch/decode side.

---
 rtl/execute_writeback.sv | 190 +++++++++++++++++++
 tb/tb_execute_writeback.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_writeback.sv
// execute_writeback: execute/writeback stage of the two-stage RV32I core.
// Resolves ALU, branch and jump results and sequences loads/stores over a req/ready port.
module execute_writeback #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic [31:0]           instruction_address,
  input  logic [31:0]           immediate,
  input  logic                  aluop1_source,
  input  logic                  aluop2_source,
  input  logic                  memory_read_enable,
  input  logic                  memory_write_enable,
  input  logic [1:0]            wb_reg_write_source,
  input  logic [31:0]           read_data1,
  input  logic [31:0]           read_data2,
  output logic [31:0]           write_data,
  output logic                  reg_write_valid,
  output logic                  jump_flag,
  output logic [31:0]           jump_address,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, next_state;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  shamt;
  logic [31:0] op1, op2, alu_result, ea, target;
  logic [31:0] load_data, load_shifted, load_value, store_wdata;
  logic [3:0]  store_wstrb;
  logic        branch_taken, is_jal, is_jalr, is_mem, mem_go;
  logic        unused_ok;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign op1      = aluop1_source ? instruction_address : read_data1;
  assign op2      = aluop2_source ? immediate : read_data2;
  assign shamt    = op2[4:0];
  assign ea       = read_data1 + immediate;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_mem   = memory_read_enable | memory_write_enable;
  assign unused_ok = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // Subtract is only meaningful for register ops; I-type bit 30 only selects srai.
  always_comb begin
    alu_result = op1 + op2;
    if (opcode == OP_LUI) begin
      alu_result = immediate;
    end else if (opcode == OP_REG || opcode == OP_IMM) begin
      case (funct3)
        3'd0: if (opcode == OP_REG && funct7_5) alu_result = op1 - op2;
        3'd1: alu_result = op1 << shamt;
        3'd2: alu_result = {31'd0, $signed(op1) < $signed(op2)};
        3'd3: alu_result = {31'd0, op1 < op2};
        3'd4: alu_result = op1 ^ op2;
        3'd5: begin
          if (funct7_5) alu_result = $signed(op1) >>> shamt;
          else          alu_result = op1 >> shamt;
        end
        3'd6: alu_result = op1 | op2;
        3'd7: alu_result = op1 & op2;
      endcase
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'd0:    branch_taken = read_data1 == read_data2;
        3'd1:    branch_taken = read_data1 != read_data2;
        3'd4:    branch_taken = $signed(read_data1) < $signed(read_data2);
        3'd5:    branch_taken = $signed(read_data1) >= $signed(read_data2);
        3'd6:    branch_taken = read_data1 < read_data2;
        3'd7:    branch_taken = read_data1 >= read_data2;
        default: branch_taken = 1'b0;
      endcase
    end
  end

  assign target       = is_jalr ? ((read_data1 + immediate) & ~32'd1) : (instruction_address + immediate);
  assign jump_flag    = (branch_taken | is_jal | is_jalr) & ~stall;
  assign jump_address = jump_flag ? target : 32'd0;

  assign misaligned = is_mem && ((funct3[1:0] == 2'b01 && ea[0]) || (funct3[1] && ea[1:0] != 2'b00));
  assign mem_go     = is_mem && !misaligned;

  always_comb begin
    store_wstrb = 4'b1111;
    store_wdata = read_data2;
    case (funct3[1:0])
      2'b00: begin
        store_wstrb = 4'b0001 << ea[1:0];
        store_wdata = {4{read_data2[7:0]}};
      end
      2'b01: begin
        store_wstrb = 4'b0011 << {ea[1], 1'b0};
        store_wdata = {2{read_data2[15:0]}};
      end
      default: ;
    endcase
  end

  // Aligned halves always start on an even lane, so one byte-granular shift serves both sizes.
  always_comb begin
    load_shifted = load_data >> {ea[1:0], 3'b000};
    case (funct3[1:0])
      2'b00:   load_value = funct3[2] ? {24'd0, load_shifted[7:0]}
                                      : {{24{load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_value = funct3[2] ? {16'd0, load_shifted[15:0]}
                                      : {{16{load_shifted[15]}}, load_shifted[15:0]};
      default: load_value = load_data;
    endcase
  end

  always_comb begin
    write_data = alu_result;
    if (misaligned)                        write_data = 32'd0;
    else if (wb_reg_write_source == 2'd1) write_data = (state == DONE) ? load_value : 32'd0;
    else if (wb_reg_write_source == 2'd3) write_data = instruction_address + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_go) next_state = REQ;
      REQ:     if (mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reset squashes the stall at once so an abandoned request never blocks the front end.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = mem_go;
      REQ:     stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (rst) stall = 1'b0;
  end

  assign reg_write_valid = ~stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      load_data <= 32'd0;
    end else if (state == IDLE && mem_go) begin
      mem_req   <= 1'b1;
      mem_we    <= memory_write_enable;
      mem_addr  <= {ea[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata <= memory_write_enable ? store_wdata : 32'd0;
      mem_wstrb <= memory_write_enable ? store_wstrb : 4'd0;
    end else if (state == REQ && mem_ready) begin
      mem_req   <= 1'b0;
      load_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_execute_writeback.sv
// tb_execute_writeback: vector table, randomized reference-model checks and
// hand-written memory/reset sequences for execute_writeback.
module tb_execute_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, instruction_address, immediate, read_data1, read_data2, mem_rdata;
  logic        aluop1_source, aluop2_source, memory_read_enable, memory_write_enable, mem_ready;
  logic [1:0]  wb_reg_write_source;
  logic [31:0] write_data, jump_address, mem_addr, mem_wdata;
  logic        reg_write_valid, jump_flag, stall, misaligned, mem_req, mem_we;
  logic [3:0]  mem_wstrb;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       name;
    logic [31:0] instr, pc, imm, rs1v, rs2v;
    logic        a1, a2;
    logic [1:0]  wb;
    logic [31:0] exp_wd;
    logic        exp_jf;
    logic [31:0] exp_ja;
  } vec_t;

  vec_t vecs[$];

  execute_writeback #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instruction_address(instruction_address),
    .immediate(immediate), .aluop1_source(aluop1_source), .aluop2_source(aluop2_source),
    .memory_read_enable(memory_read_enable), .memory_write_enable(memory_write_enable),
    .wb_reg_write_source(wb_reg_write_source), .read_data1(read_data1), .read_data2(read_data2),
    .write_data(write_data), .reg_write_valid(reg_write_valid), .jump_flag(jump_flag),
    .jump_address(jump_address), .stall(stall), .misaligned(misaligned), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  function automatic vec_t mkVec(input string name, input logic [31:0] instr, pc, imm, rs1v, rs2v,
                                 input logic a1, a2, input logic [1:0] wb,
                                 input logic [31:0] exp_wd, input logic exp_jf, input logic [31:0] exp_ja);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = pc; v.imm = imm; v.rs1v = rs1v; v.rs2v = rs2v;
    v.a1 = a1; v.a2 = a2; v.wb = wb; v.exp_wd = exp_wd; v.exp_jf = exp_jf; v.exp_ja = exp_ja;
    return v;
  endfunction

  // Instruction-level reference: what the architectural RV32I result of one bundle should be.
  function automatic void refModel(input logic [31:0] instr, pc, imm, rs1v, rs2v,
                                   input logic a1, a2, input logic [1:0] wb,
                                   output logic [31:0] wd, output logic jf, output logic [31:0] ja);
    logic [6:0]  opc = instr[6:0];
    logic [2:0]  f3  = instr[14:12];
    logic [31:0] a   = a1 ? pc : rs1v;
    logic [31:0] b   = a2 ? imm : rs2v;
    int          sa  = a;
    int          sb  = b;
    int          sh  = int'(b % 32);
    int          s1  = rs1v;
    int          s2  = rs2v;
    logic [31:0] alu = a + b;
    if (opc == 7'h37) alu = imm;
    else if (opc == 7'h33 || opc == 7'h13) begin
      case (f3)
        3'd0: alu = (opc == 7'h33 && instr[30]) ? a - b : a + b;
        3'd1: alu = a << sh;
        3'd2: alu = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: alu = (a < b) ? 32'd1 : 32'd0;
        3'd4: alu = a ^ b;
        3'd5: alu = instr[30] ? 32'(sa >>> sh) : a >> sh;
        3'd6: alu = a | b;
        3'd7: alu = a & b;
      endcase
    end
    jf = 1'b0;
    ja = 32'd0;
    if (opc == 7'h6F) begin jf = 1'b1; ja = pc + imm; end
    else if (opc == 7'h67) begin jf = 1'b1; ja = (rs1v + imm) & 32'hFFFF_FFFE; end
    else if (opc == 7'h63) begin
      case (f3)
        3'd0: jf = rs1v == rs2v;
        3'd1: jf = rs1v != rs2v;
        3'd4: jf = s1 < s2;
        3'd5: jf = s1 >= s2;
        3'd6: jf = rs1v < rs2v;
        3'd7: jf = rs1v >= rs2v;
        default: jf = 1'b0;
      endcase
      if (jf) ja = pc + imm;
    end
    wd = (wb == 2'd3) ? pc + 32'd4 : alu;
  endfunction

  task automatic applyStimulus(input logic [31:0] instr, pc, imm, rs1v, rs2v,
                               input logic a1, a2, rd_en, wr_en, input logic [1:0] wb);
    instruction = instr; instruction_address = pc; immediate = imm;
    read_data1 = rs1v; read_data2 = rs2v; aluop1_source = a1; aluop2_source = a2;
    memory_read_enable = rd_en; memory_write_enable = wr_en; wb_reg_write_source = wb;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Drives mem_ready after `delay` request cycles and returns what was seen; starts and ends at a negedge.
  task automatic runMem(input int delay, input logic [31:0] rdata, output int stall_cycles,
                        output logic [31:0] wd_done, output logic [31:0] addr_s,
                        output logic [31:0] wdata_s, output logic [3:0] strb_s, output logic we_s);
    int req_cycles = 0;
    bit done = 0;
    stall_cycles = 0; wd_done = 0; addr_s = 0; wdata_s = 0; strb_s = 0; we_s = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!stall) begin
        wd_done = write_data;
        checkOutput("rwv_done", {31'd0, reg_write_valid}, 32'd1);
        done = 1;
      end else begin
        stall_cycles++;
        if (mem_req) begin
          if (req_cycles == 0) begin
            addr_s = mem_addr; wdata_s = mem_wdata; strb_s = mem_wstrb; we_s = mem_we;
          end
          req_cycles++;
          if (req_cycles > delay) begin
            mem_ready = 1'b1;
            mem_rdata = rdata;
          end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL mem_timeout actual=stalled expected=completion");
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] wd, ja, addr_s, wdata_s, rs1v, rs2v, imm, instr, ea, rdata, exp, mask;
    logic        jf, we_s, a1, a2;
    logic [3:0]  strb_s, exp_strb;
    logic [1:0]  wb;
    int          ncyc, kind, sz, off;

    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    applyStimulus(32'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_mem_req", {31'd0, mem_req}, 0);
    checkOutput("reset_mem_regs", {mem_we, mem_wstrb, 27'd0} | mem_addr | mem_wdata, 0);
    checkOutput("reset_stall", {31'd0, stall}, 0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mkVec("addi", mk(7'h13, 0, 0), 0, 32'hFFFF_FFFD, 5, 0, 0, 1, 0, 2, 0, 0));
    vecs.push_back(mkVec("beq_taken", mk(7'h63, 0, 0), 32'h40, 32'h10, 7, 7, 1, 1, 0, 32'h50, 1, 32'h50));
    vecs.push_back(mkVec("beq_not", mk(7'h63, 0, 0), 32'h40, 32'h10, 7, 8, 1, 1, 0, 32'h50, 0, 0));
    vecs.push_back(mkVec("jalr", mk(7'h67, 0, 0), 32'h20, 4, 32'h103, 0, 0, 1, 3, 32'h24, 1, 32'h106));
    vecs.push_back(mkVec("jal", mk(7'h6F, 0, 0), 32'h100, 32'h20, 0, 0, 1, 1, 3, 32'h104, 1, 32'h120));
    vecs.push_back(mkVec("sub", mk(7'h33, 0, 7'h20), 0, 0, 10, 3, 0, 0, 0, 7, 0, 0));
    vecs.push_back(mkVec("srai", mk(7'h13, 5, 7'h20), 0, 32'h404, 32'h8000_0000, 0, 0, 1, 0, 32'hF800_0000, 0, 0));
    vecs.push_back(mkVec("srli", mk(7'h13, 5, 0), 0, 4, 32'h8000_0000, 0, 0, 1, 0, 32'h0800_0000, 0, 0));
    vecs.push_back(mkVec("addi_bit30", mk(7'h13, 0, 7'h20), 0, 32'h400, 1, 0, 0, 1, 0, 32'h401, 0, 0));
    vecs.push_back(mkVec("lui", mk(7'h37, 0, 0), 0, 32'h1234_5000, 32'hDEAD, 0, 0, 1, 0, 32'h1234_5000, 0, 0));
    vecs.push_back(mkVec("bltu", mk(7'h63, 6, 0), 32'h80, 32'hFFFF_FFF0, 1, 32'hFFFF_FFFF, 1, 1, 0, 32'h70, 1, 32'h70));
    vecs.push_back(mkVec("blt_not", mk(7'h63, 4, 0), 32'h80, 8, 1, 32'hFFFF_FFFF, 1, 1, 0, 32'h88, 0, 0));
    vecs.push_back(mkVec("slt_neg", mk(7'h33, 2, 0), 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec("bubble", 32'h13, 32'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].imm, vecs[i].rs1v, vecs[i].rs2v,
                    vecs[i].a1, vecs[i].a2, 0, 0, vecs[i].wb);
      #1;
      checkOutput({vecs[i].name, "_wd"}, write_data, vecs[i].exp_wd);
      checkOutput({vecs[i].name, "_jf"}, {31'd0, jump_flag}, {31'd0, vecs[i].exp_jf});
      checkOutput({vecs[i].name, "_ja"}, jump_address, vecs[i].exp_ja);
      checkOutput({vecs[i].name, "_ctl"}, {30'd0, stall, reg_write_valid}, 32'd1);
      @(negedge clk);
    end

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0: instr = mk(7'h33, 3'($urandom), $urandom_range(0, 1) ? 7'h20 : 7'h00);
        1: instr = mk(7'h13, 3'($urandom), $urandom_range(0, 1) ? 7'h20 : 7'h00);
        2: instr = mk(7'h37, 0, 0);
        3: instr = mk(7'h17, 0, 0);
        4: instr = mk(7'h6F, 0, 0);
        5: instr = mk(7'h67, 0, 0);
        6: begin
          sz = $urandom_range(0, 5);
          instr = mk(7'h63, (sz < 2) ? 3'(sz) : 3'(sz + 2), 0);
        end
        default: instr = $urandom_range(0, 1) ? 32'h13 : mk(7'h0B, 3'($urandom), 0);
      endcase
      rs1v = $urandom;
      rs2v = ($urandom_range(0, 3) == 0) ? rs1v : $urandom;
      imm  = $urandom;
      a1   = 1'($urandom);
      a2   = 1'($urandom);
      wb   = ($urandom_range(0, 2) == 0) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3);
      refModel(instr, $urandom, imm, rs1v, rs2v, a1, a2, wb, wd, jf, ja);
      applyStimulus(instr, 0, imm, rs1v, rs2v, a1, a2, 0, 0, wb);
      refModel(instr, instruction_address, imm, rs1v, rs2v, a1, a2, wb, wd, jf, ja);
      #1;
      checkOutput("rand_wd", write_data, wd);
      checkOutput("rand_jf", {31'd0, jump_flag}, {31'd0, jf});
      checkOutput("rand_ja", jump_address, ja);
      @(negedge clk);
    end

    applyStimulus(mk(7'h03, 0, 0), 0, 3, 32'h1000, 0, 0, 1, 1, 0, 1);
    runMem(1, 32'h80AA_BBCC, ncyc, wd, addr_s, wdata_s, strb_s, we_s);
    checkOutput("lb_stall_cycles", ncyc, 3);
    checkOutput("lb_addr", addr_s, 32'h1000);
    checkOutput("lb_we", {31'd0, we_s}, 0);
    checkOutput("lb_wd", wd, 32'hFFFF_FF80);

    applyStimulus(mk(7'h03, 4, 0), 0, 3, 32'h1000, 0, 0, 1, 1, 0, 1);
    runMem(0, 32'h80AA_BBCC, ncyc, wd, addr_s, wdata_s, strb_s, we_s);
    checkOutput("lbu_stall_cycles", ncyc, 2);
    checkOutput("lbu_wd", wd, 32'h0000_0080);

    applyStimulus(mk(7'h23, 1, 0), 0, 2, 32'h2000, 32'h1234_ABCD, 0, 1, 0, 1, 0);
    runMem(0, 0, ncyc, wd, addr_s, wdata_s, strb_s, we_s);
    checkOutput("sh_strb", {28'd0, strb_s}, 32'hC);
    checkOutput("sh_wdata_hi", {16'd0, wdata_s[31:16]}, 32'hABCD);
    checkOutput("sh_wdata", wdata_s, 32'hABCD_ABCD);
    checkOutput("sh_we_addr", {we_s, addr_s[30:0]}, 32'h8000_2000);

    applyStimulus(mk(7'h03, 2, 0), 0, 1, 32'h2000, 0, 0, 1, 1, 0, 1);
    #1;
    checkOutput("lw_mis_flag", {31'd0, misaligned}, 1);
    checkOutput("lw_mis_ctl", {30'd0, stall, reg_write_valid}, 32'd1);
    checkOutput("lw_mis_wd", write_data, 0);
    @(posedge clk); #1;
    checkOutput("lw_mis_req", {31'd0, mem_req}, 0);
    @(negedge clk);

    applyStimulus(mk(7'h03, 2, 0), 0, 0, 32'h3000, 0, 0, 1, 1, 0, 1);
    @(posedge clk); #1;
    checkOutput("rst_pre_req", {31'd0, mem_req}, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_drop", {31'd0, mem_req}, 0);
    checkOutput("rst_stall_drop", {31'd0, stall}, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk(7'h13, 0, 0), 0, 32'hFFFF_FFFD, 5, 0, 0, 1, 0, 0, 0);
    #1;
    checkOutput("post_rst_addi", write_data, 2);
    checkOutput("post_rst_ctl", {30'd0, stall, reg_write_valid}, 32'd1);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      sz   = $urandom_range(0, 2);
      ea   = $urandom & ~((32'd1 << sz) - 32'd1);
      off  = int'(ea % 4);
      rs1v = $urandom;
      imm  = ea - rs1v;
      rs2v = $urandom;
      rdata = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        kind = (sz < 2) ? $urandom_range(0, 1) : 0;
        applyStimulus(mk(7'h03, 3'(sz + 4 * kind), 0), 0, imm, rs1v, 0, 0, 1, 1, 0, 1);
        runMem($urandom_range(0, 2), rdata, ncyc, wd, addr_s, wdata_s, strb_s, we_s);
        exp = rdata >> (8 * off);
        if (sz == 0) exp = (kind == 0 && exp[7]) ? (exp & 32'hFF) | 32'hFFFF_FF00 : exp & 32'hFF;
        if (sz == 1) exp = (kind == 0 && exp[15]) ? (exp & 32'hFFFF) | 32'hFFFF_0000 : exp & 32'hFFFF;
        checkOutput("rand_load_wd", wd, exp);
        checkOutput("rand_load_addr", addr_s, ea & 32'hFFFF_FFFC);
      end else begin
        applyStimulus(mk(7'h23, 3'(sz), 0), 0, imm, rs1v, rs2v, 0, 1, 0, 1, 0);
        runMem($urandom_range(0, 2), 0, ncyc, wd, addr_s, wdata_s, strb_s, we_s);
        exp_strb = 4'(((1 << (1 << sz)) - 1) << off);
        mask = 0;
        for (int b = 0; b < 4; b++) if (exp_strb[b]) mask = mask | (32'hFF << (8 * b));
        checkOutput("rand_store_strb", {28'd0, strb_s}, {28'd0, exp_strb});
        checkOutput("rand_store_data", wdata_s & mask, (rs2v << (8 * off)) & mask);
        checkOutput("rand_store_we_addr", {we_s, addr_s[30:0]}, {1'b1, ea[30:2], 2'b00});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
